// File: rtl/pe_pkg.sv
// Shared types and constants for the PE sequencer slice.
// Mode encoding matches the pe_unit_new mode port.
package pe_pkg;

    localparam int PE_DATA_WIDTH = 16;
    localparam int PE_ACC_WIDTH  = 32;
    localparam int PE_FRAC_BITS  = 8;

    typedef enum logic [1:0] {
        MAC = 2'b00,
        EWM = 2'b01,
        EWA = 2'b10,
        ILL = 2'b11
    } pe_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } seq_state_e;

endpackage

// File: rtl/pe_res_fifo.sv
// Result FIFO of {last, data}; supports push and pop in the same
// cycle even when full.
module pe_res_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   free_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_q;
    logic [PW:0]      rd_q;
    logic [PW:0]      cnt;
    logic             wr_en;
    logic             rd_en;

    assign cnt     = wr_q - rd_q;
    assign empty_o = (cnt == '0);
    assign full_o  = (cnt == (PW+1)'(DEPTH));
    assign free_o  = (PW+1)'(DEPTH) - cnt;
    assign rd_en   = pop_i & ~empty_o;
    assign wr_en   = push_i & (~full_o | rd_en);
    assign data_o  = empty_o ? '0 : mem_q[rd_q[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + (PW+1)'(1);
            if (rd_en) rd_q <= rd_q + (PW+1)'(1);
        end
    end

    // Storage needs no reset; data_o is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[PW-1:0]] <= data_i;
    end

endmodule

// File: rtl/pe_seq_ctrl.sv
// Command sequencer for one pe_unit_new: streams operand pairs,
// closes the MAC accumulator loop and buffers results.
module pe_seq_ctrl
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int ACC_WIDTH  = PE_ACC_WIDTH,
    parameter int LEN_W      = 10,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [ACC_WIDTH-1:0]  cmd_bias,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  pe_valid_in,
    output logic [1:0]            pe_mode,
    output logic [DATA_WIDTH-1:0] pe_a,
    output logic [DATA_WIDTH-1:0] pe_b,
    output logic [ACC_WIDTH-1:0]  pe_acc_in,
    input  logic [ACC_WIDTH-1:0]  pe_result,
    input  logic                  pe_valid_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic                  res_last,
    output logic                  busy,
    output logic                  err_mode
);

    localparam int PW = $clog2(OUT_DEPTH);

    seq_state_e           state_q;
    pe_mode_e             mode_q;
    logic [LEN_W-1:0]     cnt_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 inflight_q;
    logic                 err_q;

    logic is_idle, is_run, is_drain, is_mac;
    logic cmd_hs, op_hs, last_issue, fifo_ok;
    logic len0_mac, len0_full;
    logic push, push_last;
    logic [ACC_WIDTH-1:0] push_data;
    logic [ACC_WIDTH:0]   fifo_dout;
    logic fifo_empty, fifo_full;
    logic [PW:0] fifo_free;

    assign is_idle    = (state_q == IDLE);
    assign is_run     = (state_q == RUN);
    assign is_drain   = (state_q == DRAIN);
    assign is_mac     = (mode_q == MAC);
    assign last_issue = (cnt_q == LEN_W'(1));

    // One slot must stay free for a result already inside the PE.
    assign fifo_ok   = fifo_free > (PW+1)'(inflight_q);
    assign op_ready  = is_run & ((is_mac & ~last_issue) | fifo_ok);
    assign op_hs     = op_valid & op_ready;

    assign len0_mac  = (cmd_mode == MAC) & (cmd_len == '0);
    assign len0_full = fifo_full & len0_mac;
    assign cmd_ready = is_idle & ~len0_full;
    assign cmd_hs    = cmd_valid & cmd_ready;

    assign pe_valid_in = op_hs;
    assign pe_mode     = mode_q;
    assign pe_a        = is_run ? op_a : '0;
    assign pe_b        = is_run ? op_b : '0;

    always_comb begin
        pe_acc_in = '0;
        if (is_run && is_mac)
            pe_acc_in = pe_valid_out ? pe_result : acc_q;
    end

    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        push_data = pe_result;
        unique case (1'b1)
            is_idle: begin
                push      = cmd_hs & len0_mac;
                push_last = 1'b1;
                push_data = cmd_bias;
            end
            is_run: push = pe_valid_out & ~is_mac;
            is_drain: begin
                push      = pe_valid_out;
                push_last = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= MAC;
            cnt_q      <= '0;
            acc_q      <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= op_hs;
            if (pe_valid_out && !is_idle) acc_q <= pe_result;
            unique case (state_q)
                IDLE: if (cmd_hs) begin
                    if (cmd_mode == ILL) begin
                        err_q <= 1'b1;
                    end else begin
                        mode_q <= pe_mode_e'(cmd_mode);
                        cnt_q  <= cmd_len;
                        acc_q  <= cmd_bias;
                        if (cmd_len != '0) state_q <= RUN;
                    end
                end
                RUN: if (op_hs) begin
                    cnt_q <= cnt_q - LEN_W'(1);
                    if (last_issue) state_q <= DRAIN;
                end
                DRAIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    pe_res_fifo #(
        .WIDTH (ACC_WIDTH + 1),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  ({push_last, push_data}),
        .pop_i   (res_ready),
        .data_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .free_o  (fifo_free)
    );

    assign res_valid = ~fifo_empty;
    assign res_last  = fifo_dout[ACC_WIDTH];
    assign res_data  = fifo_dout[ACC_WIDTH-1:0];
    assign busy      = ~is_idle | ~fifo_empty;
    assign err_mode  = err_q;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl with a behavioural 1-cycle PE and a
// result scoreboard fed by the stimulus thread.
module tb_pe_seq_ctrl;
    import pe_pkg::*;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int LW = 10;
    localparam int OD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_mode = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [AW-1:0] cmd_bias = '0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic          pe_valid_in;
    logic [1:0]    pe_mode;
    logic [DW-1:0] pe_a, pe_b;
    logic [AW-1:0] pe_acc_in;
    logic [AW-1:0] pe_result;
    logic          pe_valid_out;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [AW-1:0] res_data;
    logic          res_last;
    logic          busy;
    logic          err_mode;

    int checks = 0;
    int failures = 0;
    int n_issue = 0;
    int cyc = 0;
    int last_issue_cyc = 0;
    int first_issue_cyc = 0;
    logic [AW:0] exp_q[$];

    pe_seq_ctrl #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .LEN_W      (LW),
        .OUT_DEPTH  (OD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_len      (cmd_len),
        .cmd_bias     (cmd_bias),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .pe_valid_in  (pe_valid_in),
        .pe_mode      (pe_mode),
        .pe_a         (pe_a),
        .pe_b         (pe_b),
        .pe_acc_in    (pe_acc_in),
        .pe_result    (pe_result),
        .pe_valid_out (pe_valid_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_last     (res_last),
        .busy         (busy),
        .err_mode     (err_mode)
    );

    function automatic logic [AW-1:0] pe_calc(
        input logic [1:0]    m,
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [AW-1:0] acc
    );
        logic signed [AW-1:0] sa, sb;
        sa = AW'(signed'(a));
        sb = AW'(signed'(b));
        case (m)
            2'b00:   return acc + sa * sb;
            2'b01:   return sa * sb;
            2'b10:   return (sa + sb) <<< PE_FRAC_BITS;
            default: return '0;
        endcase
    endfunction

    // Stand-in for pe_unit_new: one register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_valid_out <= 1'b0;
            pe_result    <= '0;
        end else begin
            pe_valid_out <= pe_valid_in;
            if (pe_valid_in)
                pe_result <= pe_calc(pe_mode, pe_a, pe_b, pe_acc_in);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pe_valid_in) n_issue++;
    end

    always @(negedge clk) begin
        logic [AW:0] e;
        if (rst_n && res_valid && res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result got=%h last=%b required=none",
                         res_data, res_last);
            end else begin
                e = exp_q.pop_front();
                if ({res_last, res_data} !== e) begin
                    failures++;
                    $display("FAIL result got=%b_%h required=%b_%h",
                             res_last, res_data, e[AW], e[AW-1:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", nm, got, req);
        end
    endtask

    task automatic send_cmd(input logic [1:0] m, input int len,
                            input logic [AW-1:0] bias);
        bit ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_len   = LW'(len);
        cmd_bias  = bias;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            failures++;
            $display("FAIL cmd_timeout got=0 required=1");
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic send_op(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit ok = 1'b0;
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (op_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            failures++;
            $display("FAIL op_timeout got=0 required=1");
        end
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            failures++;
            $display("FAIL drain_timeout got=%0d required=0", exp_q.size());
        end
        #1;
    endtask

    logic [DW-1:0] ewm_a [8] = '{16'h0004, 16'hFFFC, 16'h0001, 16'hFFFD,
                                 16'h0002, 16'h0000, 16'hFFFE, 16'h0004};
    logic [DW-1:0] ewm_b [8] = '{16'h0003, 16'h0002, 16'hFFFF, 16'hFFFC,
                                 16'h0002, 16'h0004, 16'h0003, 16'hFFFC};
    logic [AW-1:0] ewm_r [8] = '{32'h0000000C, 32'hFFFFFFF8,
                                 32'hFFFFFFFF, 32'h0000000C,
                                 32'h00000004, 32'h00000000,
                                 32'hFFFFFFFA, 32'hFFFFFFF0};
    logic [DW-1:0] ewa_a [3] = '{16'h0003, 16'h7F00, 16'h0000};
    logic [DW-1:0] ewa_b [3] = '{16'hFFFB, 16'h0100, 16'h0000};
    logic [AW-1:0] ewa_r [3] = '{32'hFFFFFE00, 32'h00800000, 32'h0};

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_op_ready", 64'(op_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_mode), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: MAC len 4, back-to-back
        exp_q.push_back({1'b1, 32'h00018100});
        send_cmd(2'b00, 4, 32'h00000100);
        send_op(16'h0100, 16'h0200);
        send_op(16'h0080, 16'h0100);
        send_op(16'hFF00, 16'h0100);
        send_op(16'h0000, 16'h7FFF);
        wait_idle();

        // 2: EWM len 8 with consumer stalled
        for (int i = 0; i < 8; i++)
            exp_q.push_back({i == 7, ewm_r[i]});
        res_ready = 1'b0;
        n_issue   = 0;
        send_cmd(2'b01, 8, 32'h0);
        fork
            begin
                for (int i = 0; i < 8; i++) send_op(ewm_a[i], ewm_b[i]);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                chk("ewm_issued_while_stalled", 64'(n_issue), 64'd4);
                chk("ewm_op_ready_low", 64'(op_ready), 64'd0);
                chk("ewm_res_valid", 64'(res_valid), 64'd1);
                res_ready = 1'b1;
            end
        join
        wait_idle();

        // 3: EWA, back-to-back then with 2-cycle gaps
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++)
                exp_q.push_back({i == 2, ewa_r[i]});
            send_cmd(2'b10, 3, 32'h0);
            for (int i = 0; i < 3; i++) begin
                send_op(ewa_a[i], ewa_b[i]);
                if (r == 1) repeat (2) @(posedge clk);
                #1;
            end
            wait_idle();
        end

        // 4: illegal mode, then zero-length MAC
        send_cmd(2'b11, 5, 32'h0);
        chk("ill_err_mode", 64'(err_mode), 64'd1);
        chk("ill_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("ill_op_ready", 64'(op_ready), 64'd0);
        exp_q.push_back({1'b1, 32'h00001234});
        send_cmd(2'b00, 0, 32'h00001234);
        wait_idle();
        chk("err_sticky", 64'(err_mode), 64'd1);

        // 5: reset in the middle of a MAC
        send_cmd(2'b00, 10, 32'h0);
        for (int i = 0; i < 5; i++) send_op(16'h0100, 16'h0100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rst_op_ready", 64'(op_ready), 64'd0);
        chk("mid_rst_pe_valid", 64'(pe_valid_in), 64'd0);
        chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_err", 64'(err_mode), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b1, 32'h00020000});
        send_cmd(2'b00, 2, 32'h0);
        send_op(16'h0100, 16'h0100);
        send_op(16'h0200, 16'h0080);
        wait_idle();

        // 6: back-to-back MAC commands
        exp_q.push_back({1'b1, 32'h00010010});
        exp_q.push_back({1'b1, 32'h000001FE});
        send_cmd(2'b00, 2, 32'h00000010);
        send_op(16'h0300, 16'h0100);
        send_op(16'hFF00, 16'h0200);
        last_issue_cyc = cyc;
        send_cmd(2'b00, 3, 32'hFFFFFFFF);
        send_op(16'h0010, 16'h0010);
        first_issue_cyc = cyc;
        send_op(16'h0010, 16'h0010);
        send_op(16'hFFFF, 16'h0001);
        chk("b2b_issue_gap", 64'(first_issue_cyc - last_issue_cyc), 64'd3);
        wait_idle();

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
